// File: rtl/key_press_decoder_if.sv
// Key gesture bus between the debounce filter side and key_press_decoder.
//   press        : one-cycle debounced press event
//   key_n        : debounced key level, 0 = held, 1 = released
//   short_press  : one-cycle pulse, single short press confirmed
//   double_click : one-cycle pulse, second press within the gap window
//   long_press   : one-cycle pulse, key held long enough
//   repeat_tick  : one-cycle auto-repeat pulse during a long hold
//   busy         : decoder is inside a gesture
// master drives press/key_n; slave (the decoder) drives the results.
interface key_press_decoder_if;
    logic press;
    logic key_n;
    logic short_press;
    logic double_click;
    logic long_press;
    logic repeat_tick;
    logic busy;

    modport master (
        output press,
        output key_n,
        input  short_press,
        input  double_click,
        input  long_press,
        input  repeat_tick,
        input  busy
    );

    modport slave (
        input  press,
        input  key_n,
        output short_press,
        output double_click,
        output long_press,
        output repeat_tick,
        output busy
    );
endinterface

// File: rtl/key_press_decoder.sv
// Classifies debounced key gestures into short press, double click and long
// press, and emits auto-repeat ticks while a long press is held.
//   clk  : system clock, all logic on posedge
//   rst  : asynchronous reset, active-low
//   kif  : key_press_decoder_if.slave (press/key_n in, pulses + busy out)
// All outputs are registered; every pulse lasts exactly one cycle.
module key_press_decoder #(
    parameter int CNT_W      = 20,
    parameter int LONG_MAX   = 1000,
    parameter int DBL_GAP    = 500,
    parameter int REPEAT_MAX = 200
) (
    input  logic                clk,
    input  logic                rst,
    key_press_decoder_if.slave  kif
);

    typedef enum logic [2:0] {
        IDLE,
        HELD,
        LONG,
        WAIT2,
        HELD2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MAX - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_GAP - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             dbl_q, dbl_d;
    logic             long_q, long_d;
    logic             tick_q, tick_d;
    logic             busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        short_d = 1'b0;
        dbl_d   = 1'b0;
        long_d  = 1'b0;
        tick_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (kif.press) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end
            end
            HELD: begin
                // Release beats the long-press threshold in the same cycle.
                if (kif.key_n) begin
                    state_d = WAIT2;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = LONG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            LONG: begin
                if (kif.key_n) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REP_LAST) begin
                    tick_d = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT2: begin
                // A second press beats the gap timeout in the same cycle.
                if (kif.press) begin
                    dbl_d   = 1'b1;
                    state_d = HELD2;
                    cnt_d   = '0;
                end else if (cnt_q == DBL_LAST) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD2: begin
                if (kif.key_n) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            short_q <= 1'b0;
            dbl_q   <= 1'b0;
            long_q  <= 1'b0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            dbl_q   <= dbl_d;
            long_q  <= long_d;
            tick_q  <= tick_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign kif.short_press  = short_q;
    assign kif.double_click = dbl_q;
    assign kif.long_press   = long_q;
    assign kif.repeat_tick  = tick_q;
    assign kif.busy         = busy_q;

endmodule

// File: tb/tb_key_press_decoder.sv
// Directed bench for key_press_decoder with LONG_MAX=10, DBL_GAP=6,
// REPEAT_MAX=4. Output vector layout: {busy, short, double, long, repeat}.
module tb_key_press_decoder;

    localparam logic [4:0] O_IDLE  = 5'b00000;
    localparam logic [4:0] O_BUSY  = 5'b10000;
    localparam logic [4:0] O_SHORT = 5'b01000;
    localparam logic [4:0] O_DBL   = 5'b10100;
    localparam logic [4:0] O_LONG  = 5'b10010;
    localparam logic [4:0] O_TICK  = 5'b10001;

    logic clk;
    logic rst;

    key_press_decoder_if kif ();

    key_press_decoder #(
        .CNT_W      (20),
        .LONG_MAX   (10),
        .DBL_GAP    (6),
        .REPEAT_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned vectors;
    int unsigned miscompares;
    logic [4:0]  exp_q[$];

    function automatic logic [4:0] observed();
        return {kif.busy, kif.short_press, kif.double_click,
                kif.long_press, kif.repeat_tick};
    endfunction

    // Drive one cycle of stimulus, queue the result it must produce after
    // the next edge, then pop and compare once that edge has passed.
    task automatic step(input logic p, input logic k, input logic [4:0] exp,
                        input string tag);
        logic [4:0] want;
        logic [4:0] got;
        @(negedge clk);
        kif.press = p;
        kif.key_n = k;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        got  = observed();
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, got, want);
        end
    endtask

    task automatic check_now(input logic [4:0] exp, input string tag);
        logic [4:0] got;
        got = observed();
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        kif.press   = 1'b0;
        kif.key_n   = 1'b1;
        #12;
        check_now(O_IDLE, "reset_state");
        @(negedge clk);
        rst = 1'b1;
        step(0, 1, O_IDLE, "idle_quiet");
        step(0, 0, O_IDLE, "idle_keyn_ignored");
        step(0, 1, O_IDLE, "idle_quiet2");

        // Short press: held 3 cycles, released, gap times out.
        step(1, 0, O_BUSY, "sp_press");
        repeat (2) step(0, 0, O_BUSY, "sp_hold");
        step(0, 1, O_BUSY, "sp_release");
        repeat (5) step(0, 1, O_BUSY, "sp_wait");
        step(0, 1, O_SHORT, "sp_short");
        repeat (3) step(0, 1, O_IDLE, "sp_after");

        // Double click, with a third press during HELD2 ignored.
        step(1, 0, O_BUSY, "dc_press1");
        repeat (2) step(0, 0, O_BUSY, "dc_hold1");
        step(0, 1, O_BUSY, "dc_release1");
        step(0, 1, O_BUSY, "dc_gap");
        step(1, 0, O_DBL, "dc_double");
        step(1, 0, O_BUSY, "dc_third_ignored");
        step(0, 0, O_BUSY, "dc_hold2");
        step(0, 1, O_IDLE, "dc_busy_drop");
        repeat (8) step(0, 1, O_IDLE, "dc_no_short");

        // Long press with auto-repeat, held 25 cycles.
        step(1, 0, O_BUSY, "lp_press");
        repeat (9) step(0, 0, O_BUSY, "lp_hold");
        step(0, 0, O_LONG, "lp_long");
        for (int i = 12; i <= 25; i++) begin
            if ((i - 11) % 4 == 0) step(0, 0, O_TICK, "lp_tick");
            else                   step(0, 0, O_BUSY, "lp_between");
        end
        step(0, 1, O_IDLE, "lp_release");
        repeat (8) step(0, 1, O_IDLE, "lp_no_short");

        // Release exactly at the long threshold: WAIT2 path, then short.
        step(1, 0, O_BUSY, "bl_press");
        repeat (9) step(0, 0, O_BUSY, "bl_hold");
        step(0, 1, O_BUSY, "bl_release_at_thr");
        repeat (5) step(0, 1, O_BUSY, "bl_wait");
        step(0, 1, O_SHORT, "bl_short");
        step(0, 1, O_IDLE, "bl_after");

        // Second press exactly at the gap timeout: double click only.
        step(1, 0, O_BUSY, "bd_press1");
        step(0, 1, O_BUSY, "bd_release1");
        repeat (5) step(0, 1, O_BUSY, "bd_wait");
        step(1, 0, O_DBL, "bd_double_at_thr");
        step(0, 1, O_IDLE, "bd_release2");
        repeat (6) step(0, 1, O_IDLE, "bd_no_short");

        // Reset during WAIT2.
        step(1, 0, O_BUSY, "rw_press");
        step(0, 1, O_BUSY, "rw_release");
        step(0, 1, O_BUSY, "rw_wait");
        rst = 1'b0;
        #1;
        check_now(O_IDLE, "rw_async_clear");
        @(negedge clk);
        rst = 1'b1;
        repeat (8) step(0, 1, O_IDLE, "rw_no_pulse");

        // Reset during LONG, while long_press is high.
        step(1, 0, O_BUSY, "rl_press");
        repeat (9) step(0, 0, O_BUSY, "rl_hold");
        step(0, 0, O_LONG, "rl_long");
        rst = 1'b0;
        #1;
        check_now(O_IDLE, "rl_async_clear");
        kif.key_n = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (8) step(0, 1, O_IDLE, "rl_no_pulse");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
